product_accumulator: RTL and testbench

- Sits directly downstream of the 8x8 quarter-square lookup Multiplier. It consumes the 16-bit product stream `p` and accumulates vectors of products into a wide dot-product result.
- The Multiplier has no valid, reset or stall. This block tracks issue tokens through a LATENCY-deep delay line, paces issue through `issue_ready`, and hands each finished sum out over a valid/ready interface.

---
 rtl/product_accumulator.sv | 93 +++++++++
 tb/tb_product_accumulator.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Dot-product accumulator behind the unstallable quarter-square multiplier.
// Issue tokens ride a delay line alongside the multiplier so each product is summed when it lands on p.
module product_accumulator #(
   parameter int ACC_BITS = 24,
   parameter int LEN_BITS = 8,
   parameter int LATENCY  = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                issue_valid,
   input  logic                issue_sgnd,
   input  logic                issue_last,
   output logic                issue_ready,
   input  logic [15:0]         p,
   output logic [ACC_BITS-1:0] sum,
   output logic [LEN_BITS-1:0] sum_count,
   output logic                sum_overflow,
   output logic                sum_valid,
   input  logic                sum_ready
);

   // Stage 0 captures the issue edge; stage LATENCY is the one lined up with p.
   logic [LATENCY:0] v_pipe, s_pipe, l_pipe;
   logic             dv, ds, dl, done, last_in_flight;

   logic [ACC_BITS-1:0] acc, base, ext, new_acc;
   logic [ACC_BITS:0]   add_full;
   logic [LEN_BITS-1:0] cnt, new_cnt;
   logic                ovf, first, sgn_ovf, elem_ovf, new_ovf;

   assign dv   = v_pipe[LATENCY];
   assign ds   = s_pipe[LATENCY];
   assign dl   = l_pipe[LATENCY];
   assign done = dv & dl;

   // Blocking a new vector end until the previous one has landed keeps the
   // result register free whenever a completion reaches the tail.
   assign last_in_flight = |(v_pipe & l_pipe);
   assign issue_ready    = ~last_in_flight & (~sum_valid | sum_ready);

   assign ext      = ds ? {{(ACC_BITS-16){p[15]}}, p} : {{(ACC_BITS-16){1'b0}}, p};
   assign base     = first ? '0 : acc;
   assign add_full = {1'b0, base} + {1'b0, ext};
   assign new_acc  = add_full[ACC_BITS-1:0];
   assign sgn_ovf  = (base[ACC_BITS-1] == ext[ACC_BITS-1]) &
                     (new_acc[ACC_BITS-1] != base[ACC_BITS-1]);
   assign elem_ovf = ds ? sgn_ovf : add_full[ACC_BITS];
   assign new_ovf  = (~first & ovf) | elem_ovf;
   assign new_cnt  = first ? LEN_BITS'(1) : ((&cnt) ? cnt : cnt + LEN_BITS'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_pipe <= '0;
         s_pipe <= '0;
         l_pipe <= '0;
      end else begin
         v_pipe <= {v_pipe[LATENCY-1:0], issue_valid & issue_ready};
         s_pipe <= {s_pipe[LATENCY-1:0], issue_sgnd};
         l_pipe <= {l_pipe[LATENCY-1:0], issue_last};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc   <= '0;
         cnt   <= '0;
         ovf   <= 1'b0;
         first <= 1'b1;
      end else if (dv) begin
         acc   <= new_acc;
         cnt   <= new_cnt;
         ovf   <= new_ovf;
         first <= dl;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum          <= '0;
         sum_count    <= '0;
         sum_overflow <= 1'b0;
         sum_valid    <= 1'b0;
      end else if (done) begin
         sum          <= new_acc;
         sum_count    <= new_cnt;
         sum_overflow <= new_ovf;
         sum_valid    <= 1'b1;
      end else if (sum_ready) begin
         sum_valid    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: behavioural multiplier feeding p, plus a vector-level reference model.
module tb_product_accumulator;
   localparam int ACC_BITS = 24;
   localparam int LEN_BITS = 8;
   localparam int LATENCY  = 2;
   localparam longint M24  = 64'd16777216;
   localparam longint H23  = 64'd8388608;

   logic clk = 1'b0;
   logic rst, issue_valid, issue_sgnd, issue_last, issue_ready;
   logic sum_ready, sum_overflow, sum_valid;
   logic [15:0] p;
   logic [ACC_BITS-1:0] sum;
   logic [LEN_BITS-1:0] sum_count;
   logic [7:0] a, b;
   int total = 0, bad = 0;

   always #5 clk = ~clk;

   product_accumulator #(.ACC_BITS(ACC_BITS), .LEN_BITS(LEN_BITS), .LATENCY(LATENCY)) dut (
      .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_sgnd(issue_sgnd),
      .issue_last(issue_last), .issue_ready(issue_ready), .p(p), .sum(sum),
      .sum_count(sum_count), .sum_overflow(sum_overflow), .sum_valid(sum_valid),
      .sum_ready(sum_ready));

   // Multiplier stand-in: operands seen at edge E show up on p right after edge E+LATENCY.
   function automatic logic [15:0] mul16(input logic [7:0] x, input logic [7:0] y, input logic sg);
      logic signed [15:0] sx, sy;
      sx = sg ? {{8{x[7]}}, x} : {8'b0, x};
      sy = sg ? {{8{y[7]}}, y} : {8'b0, y};
      return 16'(sx * sy);
   endfunction

   logic [15:0] mp [0:LATENCY];
   always @(posedge clk) begin
      mp[0] <= mul16(a, b, issue_sgnd);
      for (int i = 1; i <= LATENCY; i++) mp[i] <= mp[i-1];
   end
   assign p = mp[LATENCY];

   // Reference model: whole elements with integer arithmetic, completion scheduled LATENCY+1 edges out.
   longint m_acc, pend_sum, exp_sum, base, bs, r, pr, sa, sb;
   int     m_cnt, pend_cnt, exp_cnt, pend_due, cyc;
   bit     m_ovf, m_first, pend, pend_ovf, exp_ovf, exp_sv, ov, rdy;
   logic   exp_rdy;
   assign exp_rdy = !pend && (!exp_sv || sum_ready);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_acc = 0; m_cnt = 0; m_ovf = 0; m_first = 1; pend = 0; cyc = 0;
         exp_sum = 0; exp_cnt = 0; exp_ovf = 0; exp_sv = 0;
      end else begin
         rdy = exp_rdy;
         cyc++;
         if (exp_sv && sum_ready) exp_sv = 0;
         if (pend && pend_due == cyc) begin
            exp_sum = pend_sum; exp_cnt = pend_cnt; exp_ovf = pend_ovf; exp_sv = 1; pend = 0;
         end
         if (issue_valid && rdy) begin
            sa = issue_sgnd && a >= 128 ? longint'(a) - 256 : longint'(a);
            sb = issue_sgnd && b >= 128 ? longint'(b) - 256 : longint'(b);
            pr = sa * sb;
            base = m_first ? 0 : m_acc;
            if (issue_sgnd) begin
               bs = base >= H23 ? base - M24 : base;
               r  = bs + pr;
               ov = (r < -H23) || (r >= H23);
            end else begin
               r  = base + pr;
               ov = r >= M24;
            end
            m_acc = ((r % M24) + M24) % M24;
            m_cnt = m_first ? 1 : (m_cnt < 255 ? m_cnt + 1 : 255);
            m_ovf = (m_first ? 1'b0 : m_ovf) | ov;
            m_first = issue_last;
            if (issue_last) begin
               pend = 1; pend_due = cyc + LATENCY + 1;
               pend_sum = m_acc; pend_cnt = m_cnt; pend_ovf = m_ovf;
            end
         end
      end
   end

   // Holds one element until the DUT takes it; returns on the negedge after acceptance.
   task automatic send(input logic [7:0] xa, input logic [7:0] xb, input logic sg, input logic last);
      logic took;
      took = 1'b0;
      a = xa; b = xb; issue_sgnd = sg; issue_last = last; issue_valid = 1'b1;
      for (int n = 0; n < 200 && !took; n++) begin
         #1 took = issue_ready;
         @(negedge clk);
      end
      if (!took) begin
         total++; bad++;
         $display("FAIL send_timeout: element %0d*%0d not accepted, ready=%b want 1", xa, xb, issue_ready);
      end
   endtask

   task automatic idle(input int n);
      issue_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_result();
      int n;
      for (n = 0; n < 100 && !sum_valid; n++) @(negedge clk);
      total++;
      if (!sum_valid) begin
         bad++;
         $display("FAIL result_timeout: sum_valid=%b want 1", sum_valid);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; issue_valid = 1'b0; issue_sgnd = 1'b0; issue_last = 1'b0;
      sum_ready = 1'b1; a = 8'd0; b = 8'd0;
      repeat (3) @(negedge clk);
      total++; if (sum !== '0) begin bad++; $display("FAIL reset_sum: got %0d want 0", sum); end
      total++; if (sum_count !== '0) begin bad++; $display("FAIL reset_count: got %0d want 0", sum_count); end
      total++; if (sum_overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", sum_overflow); end
      total++; if (sum_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", sum_valid); end
      rst = 1'b0;
      @(negedge clk);
      total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", issue_ready); end
   endtask

   task automatic test_unsigned();
      sum_ready = 1'b1;
      send(8'd3, 8'd4, 1'b0, 1'b0);
      send(8'd5, 8'd6, 1'b0, 1'b1);
      issue_valid = 1'b0;
      for (int k = 1; k <= 2; k++) begin
         @(negedge clk);
         total++; if (sum_valid !== 1'b0) begin bad++; $display("FAIL uns_early_valid: edge+%0d got %b want 0", k, sum_valid); end
      end
      @(negedge clk);
      total++; if (sum_valid !== 1'b1) begin bad++; $display("FAIL uns_latency: got %b want 1", sum_valid); end
      total++; if (sum !== 24'd42) begin bad++; $display("FAIL uns_sum: got %0d want 42", sum); end
      total++; if (sum_count !== 8'd2) begin bad++; $display("FAIL uns_count: got %0d want 2", sum_count); end
      total++; if (sum_overflow !== 1'b0) begin bad++; $display("FAIL uns_ovf: got %b want 0", sum_overflow); end
      @(negedge clk);
      total++; if (sum_valid !== 1'b0) begin bad++; $display("FAIL uns_pulse: got %b want 0", sum_valid); end
   endtask

   task automatic test_signed();
      send(8'hFE, 8'd3, 1'b1, 1'b0);
      send(8'd4, 8'hFB, 1'b1, 1'b1);
      idle(0);
      wait_result();
      total++; if (sum !== 24'hFFFFE6) begin bad++; $display("FAIL sgn_sum: got %h want ffffe6", sum); end
      total++; if (sum_count !== 8'd2) begin bad++; $display("FAIL sgn_count: got %0d want 2", sum_count); end
      total++; if (sum_overflow !== 1'b0) begin bad++; $display("FAIL sgn_ovf: got %b want 0", sum_overflow); end
      idle(2);
   endtask

   task automatic test_single();
      send(8'd200, 8'd100, 1'b0, 1'b1);
      idle(0);
      wait_result();
      total++; if (sum !== 24'd20000) begin bad++; $display("FAIL single_sum: got %0d want 20000", sum); end
      total++; if (sum_count !== 8'd1) begin bad++; $display("FAIL single_count: got %0d want 1", sum_count); end
      idle(2);
   endtask

   task automatic test_overflow();
      longint want;
      want = (259 * 64'd65025) % M24;
      for (int i = 0; i < 258; i++) send(8'd255, 8'd255, 1'b0, 1'b0);
      send(8'd255, 8'd255, 1'b0, 1'b1);
      idle(0);
      wait_result();
      total++; if (sum_overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", sum_overflow); end
      total++; if (sum !== want[ACC_BITS-1:0]) begin bad++; $display("FAIL ovf_sum: got %0d want %0d", sum, want); end
      total++; if (sum_count !== 8'd255) begin bad++; $display("FAIL ovf_sat_count: got %0d want 255", sum_count); end
      idle(1);
      send(8'd1, 8'd1, 1'b0, 1'b1);
      idle(0);
      wait_result();
      total++; if (sum !== 24'd1) begin bad++; $display("FAIL ovf_next_sum: got %0d want 1", sum); end
      total++; if (sum_overflow !== 1'b0) begin bad++; $display("FAIL ovf_next_flag: got %b want 0", sum_overflow); end
      total++; if (sum_count !== 8'd1) begin bad++; $display("FAIL ovf_next_count: got %0d want 1", sum_count); end
      idle(2);
   endtask

   task automatic test_backpressure();
      logic [ACC_BITS-1:0] held;
      sum_ready = 1'b0;
      send(8'd3, 8'd4, 1'b0, 1'b1);
      idle(0);
      wait_result();
      held = sum;
      fork
         begin
            send(8'd7, 8'd7, 1'b0, 1'b0);
            send(8'd1, 8'd2, 1'b0, 1'b1);
            issue_valid = 1'b0;
         end
         begin
            for (int k = 0; k < 5; k++) begin
               @(negedge clk);
               #2;
               total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_low: got %b want 0", issue_ready); end
               total++; if (sum !== held || sum_valid !== 1'b1) begin
                  bad++; $display("FAIL bp_hold: sum %0d valid %b want %0d valid 1", sum, sum_valid, held);
               end
            end
            @(negedge clk);
            sum_ready = 1'b1;
         end
      join
      #1;
      total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL bp_last_inflight: got %b want 0", issue_ready); end
      @(negedge clk);
      wait_result();
      total++; if (sum !== 24'd51) begin bad++; $display("FAIL bp_sum: got %0d want 51", sum); end
      total++; if (sum_count !== 8'd2) begin bad++; $display("FAIL bp_count: got %0d want 2", sum_count); end
      idle(2);
   endtask

   task automatic test_reset_mid();
      send(8'd9, 8'd9, 1'b0, 1'b0);
      send(8'd9, 8'd9, 1'b0, 1'b0);
      rst = 1'b1; issue_valid = 1'b0;
      #1;
      total++; if (sum !== '0 || sum_count !== '0 || sum_overflow !== 1'b0 || sum_valid !== 1'b0) begin
         bad++; $display("FAIL mid_reset_outputs: sum %0d cnt %0d ovf %b vld %b want all 0", sum, sum_count, sum_overflow, sum_valid);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      send(8'd2, 8'd3, 1'b0, 1'b1);
      idle(0);
      wait_result();
      total++; if (sum !== 24'd6) begin bad++; $display("FAIL mid_sum: got %0d want 6", sum); end
      total++; if (sum_count !== 8'd1) begin bad++; $display("FAIL mid_count: got %0d want 1", sum_count); end
      idle(2);
   endtask

   task automatic test_random();
      logic took;
      took = 1'b1;
      issue_valid = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         total++; if (sum_valid !== exp_sv) begin bad++; $display("FAIL rnd_valid: cyc %0d got %b want %b", i, sum_valid, exp_sv); end
         total++; if (sum !== exp_sum[ACC_BITS-1:0]) begin bad++; $display("FAIL rnd_sum: cyc %0d got %0d want %0d", i, sum, exp_sum); end
         total++; if (sum_count !== LEN_BITS'(exp_cnt)) begin bad++; $display("FAIL rnd_count: cyc %0d got %0d want %0d", i, sum_count, exp_cnt); end
         total++; if (sum_overflow !== exp_ovf) begin bad++; $display("FAIL rnd_ovf: cyc %0d got %b want %b", i, sum_overflow, exp_ovf); end
         if (!issue_valid || took) begin
            issue_valid = ($urandom_range(0, 3) != 0);
            a = 8'($urandom);
            b = 8'($urandom);
            issue_sgnd = 1'($urandom);
            issue_last = ($urandom_range(0, 3) == 0);
         end
         sum_ready = ($urandom_range(0, 3) != 0);
         #1;
         total++; if (issue_ready !== exp_rdy) begin bad++; $display("FAIL rnd_ready: cyc %0d got %b want %b", i, issue_ready, exp_rdy); end
         took = issue_ready;
      end
      issue_valid = 1'b0;
      sum_ready = 1'b1;
      repeat (10) @(negedge clk);
      total++; if (sum !== exp_sum[ACC_BITS-1:0] || sum_valid !== exp_sv) begin
         bad++; $display("FAIL rnd_drain: sum %0d vld %b want %0d vld %b", sum, sum_valid, exp_sum, exp_sv);
      end
   endtask

   initial begin
      rst = 1'b1;
      @(negedge clk);
      test_reset();
      test_unsigned();
      test_signed();
      test_single();
      test_overflow();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
